stream_byte_packer: RTL and testbench
=====================================

// Module: stream_byte_packer
// PURPOSE
//   Parametrised successor to the compression-path aligner. Packs variable-length,
//   LSB-aligned compressed beats into dense OUT_BYTES-wide words with full
//   valid/ready handshakes on both sides, byte-granular keep, and end-of-stream
//   flush. Uncompressed/header beats pass through a bypass slot after any residue
//   is flushed. Sits between the compressor core and the AXI-Stream output DMA.
// PARAMETERS
//   IN_BYTES   34  input beat width in bytes (s_data = IN_BYTES*8 bits)
//   OUT_BYTES  32  output word width in bytes; IN_BYTES >= OUT_BYTES+TAG_BYTES
//   TAG_BYTES  2   tag bytes at LSB of a bypass beat, stripped on output
//   LEN_W      $clog2(IN_BYTES+1)  width of s_len
// PORTS
//   clk        in   1            single clock, rising edge
//   reset      in   1            asynchronous, active-high
//   s_valid    in   1            input beat valid
//   s_ready    out  1            input beat accepted when s_valid & s_ready
//   s_data     in   IN_BYTES*8   payload, valid bytes LSB-aligned
//   s_len      in   LEN_W        valid byte count 0..IN_BYTES (ignored if s_bypass)
//   s_bypass   in   1            1 = uncompressed/header beat
//   s_last     in   1            last beat of stream
//   m_valid    out  1            output word valid
//   m_ready    in   1            output word accepted when m_valid & m_ready
//   m_data     out  OUT_BYTES*8  packed word, byte 0 at LSB
//   m_keep     out  OUT_BYTES    byte enables, contiguous from bit 0
//   m_last     out  1            last word of stream
//   err_len    out  1            sticky: s_len > IN_BYTES seen (len clamped)
// BEHAVIOUR
//   - Reset (async): fill=0, flush_pend=0, byp_valid=0; m_valid=0, m_last=0,
//     m_keep=0, s_ready=0 while reset asserted, err_len=0. Mid-stream reset drops all
//     buffered bytes; first beat after release starts a new stream.
//   - State: buffer buf[OUT_BYTES+IN_BYTES bytes], fill counter 0..OUT_BYTES+IN_BYTES,
//     flush_pend flag, bypass slot {byp_data[OUT_BYTES*8], byp_last, byp_valid}.
//   - s_ready = !flush_pend & !byp_valid & (fill <= OUT_BYTES); registered state only,
//     no combinational path from m_ready or s_* to s_ready.
//   - Output select: if fill >= OUT_BYTES, or fill>0 & (flush_pend|byp_valid): packed
//     word buf[0 +: OUT_BYTES], m_keep = fill>=OUT_BYTES ? all-ones : (1<<fill)-1,
//     m_last = flush_pend & (fill <= OUT_BYTES). Else if byp_valid & fill==0: bypass
//     word, m_keep all-ones, m_last=byp_last. Else m_valid=0.
//   - Output accept (packed): buf shifts down OUT_BYTES bytes, fill -= min(fill,OUT_BYTES);
//     flush_pend clears when m_last word accepted. Bypass accept clears byp_valid.
//   - Compressed accept: s_data bytes [0,len) written at byte offset fill_after_pop,
//     where fill_after_pop = fill minus bytes popped the same cycle; fill_next =
//     fill_after_pop + len. Bytes above len are masked, never ORed in. s_last sets
//     flush_pend (even with len=0; if fill becomes 0, no word emitted, flush_pend clears).
//   - Bypass accept: byp_data = s_data[TAG_BYTES*8 +: OUT_BYTES*8], byp_last = s_last;
//     residue is emitted first as a partial word with m_last=0.
//   - Simultaneous in/out in one cycle is supported; throughput 1 word/cycle when
//     m_ready=1. Latency: accepted byte visible on m_data next cycle at earliest.
//   - m_data/m_keep/m_last stable while m_valid & !m_ready.
//   - len > IN_BYTES: treated as IN_BYTES, err_len set until reset.
// STRUCTURE
//   - Package stream_packer_pkg: default widths, keep_from_count() function, fill type.
//   - Sub-module byte_lane_shifter: masks by len and shifts input left by byte offset
//     (barrel shifter, log2 stages, combinational). Top holds FSM/counters/buffer.
// TESTING
//   - IN=34,OUT=32: 4 beats len=16, s_last on 4th, m_ready=1 -> 2 words keep=FFFFFFFF,
//     second m_last=1; bytes in order 0..63.
//   - len=20 x3 with s_last -> words of 32,28 bytes; 2nd keep=0FFFFFFF, m_last=1.
//   - fill=10 then bypass beat (tag 0xABCD, s_last=1) -> partial word keep=000003FF
//     m_last=0, then bypass word = s_data[16+:256], keep all-ones, m_last=1.
//   - m_ready toggling 1/0 random with len random 0..34 -> scoreboard byte stream exact,
//     outputs stable under stall, no loss; s_ready never high with fill > 32.
//   - Assert reset mid-stream with fill=25 -> next cycle m_valid=0; new stream after
//     release packs from byte 0, no stale bytes.
//   - s_len=40 -> err_len=1, 34 bytes packed; s_last with len=0 at fill=0 -> no word.

Source files
------------

// File: rtl/stream_packer_pkg.sv
// Shared widths, fill-counter type and keep-mask helper for the byte packer.
// Pure definitions; no timing or backpressure of its own.
package stream_packer_pkg;
  localparam int DEF_IN_BYTES  = 34;
  localparam int DEF_OUT_BYTES = 32;
  localparam int DEF_TAG_BYTES = 2;
  localparam int MAX_KEEP      = 128;

  // Wide enough for any buffer of up to 255 bytes (OUT_BYTES + IN_BYTES).
  typedef logic [7:0] fill_t;

  function automatic logic [MAX_KEEP-1:0] keep_from_count(input fill_t cnt, input int n);
    logic [MAX_KEEP-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_KEEP; i++) begin
      k[i] = (i < int'(cnt)) && (i < n);
    end
    return k;
  endfunction
endpackage

// File: rtl/byte_lane_shifter.sv
// Masks an input beat to its first len bytes and shifts it up by offset bytes.
// Purely combinational, log2(offset range) mux stages; no backpressure.
module byte_lane_shifter #(
  parameter int IN_BYTES  = 34,
  parameter int BUF_BYTES = 66,
  parameter int LEN_W     = 6,
  parameter int OFF_W     = 6
) (
  input  logic [IN_BYTES*8-1:0]  data,
  input  logic [LEN_W-1:0]       len,
  input  logic [OFF_W-1:0]       offset,
  output logic [BUF_BYTES*8-1:0] shifted
);
  logic [BUF_BYTES*8-1:0] stg [0:OFF_W];

  always_comb begin
    stg[0] = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (i < int'(len)) stg[0][i*8 +: 8] = data[i*8 +: 8];
    end
    for (int k = 0; k < OFF_W; k++) begin
      stg[k+1] = offset[k] ? (stg[k] << (8 * (1 << k))) : stg[k];
    end
    shifted = stg[OFF_W];
  end
endmodule

// File: rtl/stream_byte_packer.sv
// Packs LSB-aligned variable-length beats into dense OUT_BYTES words, with a bypass slot.
// Accepted byte visible on m_data next cycle at earliest; s_ready depends on registered state only.
module stream_byte_packer
  import stream_packer_pkg::*;
#(
  parameter int IN_BYTES  = DEF_IN_BYTES,
  parameter int OUT_BYTES = DEF_OUT_BYTES,
  parameter int TAG_BYTES = DEF_TAG_BYTES,
  parameter int LEN_W     = $clog2(IN_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_BYTES*8-1:0]  s_data,
  input  logic [LEN_W-1:0]       s_len,
  input  logic                   s_bypass,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_BYTES*8-1:0] m_data,
  output logic [OUT_BYTES-1:0]   m_keep,
  output logic                   m_last,
  output logic                   err_len
);
  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES;
  localparam int OFF_W     = $clog2(OUT_BYTES + 1);
  localparam fill_t OUT_F  = fill_t'(OUT_BYTES);
  localparam logic [LEN_W-1:0] IN_L = LEN_W'(IN_BYTES);

  logic [BUF_BYTES*8-1:0] pk_buf, buf_pop, buf_nxt, ins;
  logic [OUT_BYTES*8-1:0] byp_data;
  fill_t                  fill, fill_pop, fill_nxt;
  logic                   flush_pend, byp_valid, byp_last, run;
  logic                   pk_sel, by_sel, pop_pk, pop_by;
  logic                   s_acc, comp_acc, byp_acc, len_ovf;
  logic [LEN_W-1:0]       len_c;

  // run holds s_ready low while reset is asserted even though fill is zero.
  assign s_ready = run & !flush_pend & !byp_valid & (fill <= OUT_F);

  assign pk_sel  = (fill >= OUT_F) | ((fill != '0) & (flush_pend | byp_valid));
  assign by_sel  = !pk_sel & byp_valid;
  assign m_valid = pk_sel | by_sel;
  assign m_data  = pk_sel ? pk_buf[OUT_BYTES*8-1:0] : byp_data;
  assign m_keep  = pk_sel ? OUT_BYTES'(keep_from_count(fill, OUT_BYTES)) : {OUT_BYTES{by_sel}};
  assign m_last  = pk_sel ? (flush_pend & (fill <= OUT_F)) : (by_sel & byp_last);

  assign pop_pk   = pk_sel & m_ready;
  assign pop_by   = by_sel & m_ready;
  assign s_acc    = s_valid & s_ready;
  assign comp_acc = s_acc & !s_bypass;
  assign byp_acc  = s_acc & s_bypass;
  assign len_ovf  = s_len > IN_L;
  assign len_c    = len_ovf ? IN_L : s_len;

  byte_lane_shifter #(
    .IN_BYTES (IN_BYTES),
    .BUF_BYTES(BUF_BYTES),
    .LEN_W    (LEN_W),
    .OFF_W    (OFF_W)
  ) u_shift (
    .data   (s_data),
    .len    (len_c),
    .offset (fill_pop[OFF_W-1:0]),
    .shifted(ins)
  );

  // New bytes land above whatever survives this cycle's pop; bytes above fill are always zero.
  always_comb begin
    fill_pop = fill;
    buf_pop  = pk_buf;
    if (pop_pk) begin
      fill_pop = (fill >= OUT_F) ? (fill - OUT_F) : '0;
      buf_pop  = pk_buf >> (OUT_BYTES * 8);
    end
    fill_nxt = fill_pop;
    buf_nxt  = buf_pop;
    if (comp_acc) begin
      fill_nxt = fill_pop + fill_t'(len_c);
      buf_nxt  = buf_pop | ins;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run        <= 1'b0;
      fill       <= '0;
      pk_buf     <= '0;
      flush_pend <= 1'b0;
      byp_valid  <= 1'b0;
      byp_last   <= 1'b0;
      byp_data   <= '0;
      err_len    <= 1'b0;
    end else begin
      run    <= 1'b1;
      fill   <= fill_nxt;
      pk_buf <= buf_nxt;
      if (pop_pk && m_last) flush_pend <= 1'b0;
      // An end-of-stream with nothing buffered produces no word at all.
      if (comp_acc && s_last) flush_pend <= (fill_nxt != '0);
      if (pop_by) byp_valid <= 1'b0;
      if (byp_acc) begin
        byp_valid <= 1'b1;
        byp_data  <= s_data[TAG_BYTES*8 +: OUT_BYTES*8];
        byp_last  <= s_last;
      end
      if (comp_acc && len_ovf) err_len <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed and randomised stimulus for stream_byte_packer, checked by a queue-based scoreboard.
module tb_stream_byte_packer;
  logic         clk, reset;
  logic         s_valid, s_ready, s_bypass, s_last;
  logic [271:0] s_data;
  logic [5:0]   s_len;
  logic         m_valid, m_ready, m_last, err_len;
  logic [255:0] m_data;
  logic [31:0]  m_keep;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  int         tests = 0;
  int         fails = 0;
  bit         rnd_rdy = 0;

  stream_byte_packer dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len),
    .s_bypass(s_bypass), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .err_len(err_len)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [271:0] mk_in(input int base, input int n);
    logic [271:0] d;
    for (int i = 0; i < 34; i++) d[i*8 +: 8] = (i < n) ? 8'(base + i) : 8'hEE;
    return d;
  endfunction

  function automatic logic [255:0] mk_word(input int base, input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i*8 +: 8] = 8'(base + i);
    return w;
  endfunction

  function automatic logic [31:0] mk_keep(input int n);
    logic [31:0] k;
    for (int i = 0; i < 32; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic void expect_word(input logic [255:0] d, input logic [31:0] k, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endfunction

  // Reference packer for the random phase: a byte queue cut into 32-byte words.
  function automatic void emit(input int n, input logic lst);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i*8 +: 8] = pend.pop_front();
    expect_word(w, mk_keep(n), lst);
  endfunction

  function automatic void model_beat(input logic [271:0] d, input int len, input logic byp, input logic lst);
    if (byp) begin
      if (pend.size() > 0) emit(pend.size(), 1'b0);
      expect_word(d[16 +: 256], 32'hFFFFFFFF, lst);
    end else begin
      for (int i = 0; i < len; i++) pend.push_back(d[i*8 +: 8]);
      while (pend.size() > 32 || (!lst && pend.size() == 32)) emit(32, 1'b0);
      if (lst && pend.size() > 0) emit(pend.size(), 1'b1);
    end
  endfunction

  task automatic send(input logic [271:0] d, input logic [5:0] len, input logic byp, input logic lst);
    int t;
    t = 0;
    s_valid = 1; s_data = d; s_len = len; s_bypass = byp; s_last = lst;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 1000);
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    s_valid = 0; s_last = 0; s_bypass = 0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", nm, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, hold-under-stall and the fill bound while accepting.
  initial begin
    logic [289:0] prev;
    bit           prev_stall;
    exp_t         e;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("stall_stable", 320'({m_valid, m_last, m_keep, m_data}), 320'(prev));
        if (s_ready) chk("s_ready_fill", 320'(dut.fill > 8'd32), 320'(0));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word: got data %h keep %h last %b, required none", m_data, m_keep, m_last);
          end else begin
            e = exp_q.pop_front();
            chk("word", 320'({m_data, m_keep, m_last}), 320'({e.d, e.k, e.l}));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev = {m_valid, m_last, m_keep, m_data};
      end
    end
  end

  initial begin
    logic [271:0] d;
    int           len;
    logic         byp;
    reset = 1; s_valid = 0; s_data = '0; s_len = '0; s_bypass = 0; s_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 320'(s_ready), 320'(0));
    chk("rst_m_valid", 320'(m_valid), 320'(0));
    chk("rst_m_keep",  320'(m_keep),  320'(0));
    chk("rst_m_last",  320'(m_last),  320'(0));
    chk("rst_err_len", 320'(err_len), 320'(0));
    @(posedge clk);
    #1 reset = 0;

    // Four 16-byte beats -> two full words carrying bytes 0..63.
    expect_word(mk_word(0, 32), 32'hFFFFFFFF, 1'b0);
    expect_word(mk_word(32, 32), 32'hFFFFFFFF, 1'b1);
    for (int j = 0; j < 4; j++) send(mk_in(16 * j, 16), 6'd16, 1'b0, j == 3);
    wait_idle("len16");

    // Three 20-byte beats -> 32 bytes then a 28-byte final word.
    expect_word(mk_word(0, 32), 32'hFFFFFFFF, 1'b0);
    expect_word(mk_word(32, 28), 32'h0FFFFFFF, 1'b1);
    for (int j = 0; j < 3; j++) send(mk_in(20 * j, 20), 6'd20, 1'b0, j == 2);
    wait_idle("len20");

    // Ten bytes of residue, then a tagged bypass beat closing the stream.
    d = mk_in(8'h4E, 34);
    d[15:0] = 16'hABCD;
    expect_word(mk_word(0, 10), 32'h000003FF, 1'b0);
    expect_word(mk_word(8'h50, 32), 32'hFFFFFFFF, 1'b1);
    send(mk_in(0, 10), 6'd10, 1'b0, 1'b0);
    send(d, 6'd0, 1'b1, 1'b1);
    wait_idle("bypass");

    // Oversized length clamps to 34 bytes and raises the sticky error.
    expect_word(mk_word(8'h60, 32), 32'hFFFFFFFF, 1'b0);
    expect_word(mk_word(8'h80, 2), 32'h00000003, 1'b1);
    send(mk_in(8'h60, 34), 6'd40, 1'b0, 1'b0);
    send(mk_in(0, 0), 6'd0, 1'b0, 1'b1);
    wait_idle("len40");
    chk("err_len_set", 320'(err_len), 320'(1));

    // Empty end-of-stream with nothing buffered emits nothing.
    send(mk_in(0, 0), 6'd0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("len0_no_word", 320'(m_valid), 320'(0));
    end
    chk("len0_ready_back", 320'(s_ready), 320'(1));
    @(posedge clk);
    #1;

    // Reset with 25 bytes buffered; the next stream must start clean.
    send(mk_in(8'h10, 25), 6'd25, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("midrst_m_valid", 320'(m_valid), 320'(0));
    chk("midrst_s_ready", 320'(s_ready), 320'(0));
    chk("midrst_err_len", 320'(err_len), 320'(0));
    @(posedge clk);
    #1 reset = 0;
    expect_word(mk_word(8'hA0, 32), 32'hFFFFFFFF, 1'b1);
    send(mk_in(8'hA0, 32), 6'd32, 1'b0, 1'b1);
    wait_idle("after_reset");

    // Random lengths, occasional bypass beats, m_ready toggling.
    rnd_rdy = 1;
    for (int j = 0; j < 80; j++) begin
      for (int i = 0; i < 34; i++) d[i*8 +: 8] = 8'($urandom);
      byp = ($urandom_range(0, 5) == 0) && (j != 79);
      len = (j == 79) ? $urandom_range(1, 34) : $urandom_range(0, 34);
      model_beat(d, len, byp, j == 79);
      send(d, 6'(len), byp, j == 79);
    end
    wait_idle("random");
    rnd_rdy = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
